// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter sharing one LCG random engine among NUM_REQ requesters.
// A reseed arriving mid-delivery is parked and applied in the next IDLE cycle.
module rng_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 3,
    parameter int MULT    = 5,
    parameter int INC     = 3,
    parameter int SEED    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [WIDTH-1:0]   rnd_out,
    output logic               rnd_valid,
    input  logic               reseed,
    input  logic [WIDTH-1:0]   seed_in,
    output logic               busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = WIDTH + 32;

    typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lcg, lcg_step, seed_cap;
    logic [IW-1:0]    rr_last, winner, pick;
    logic             pick_vld, reseed_pend, apply_seed;
    logic [PW-1:0]    prod;

    // Full-width product, truncated only after the increment.
    always_comb begin
        prod     = PW'(lcg) * PW'(MULT) + PW'(INC);
        lcg_step = prod[WIDTH-1:0];
    end

    // Scan downward so the lowest offset from rr_last wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (req[IW'(idx)]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign apply_seed = (state == IDLE) && (reseed || reseed_pend);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!apply_seed && pick_vld) state_nxt = GRANT;
            GRANT:   state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcg         <= WIDTH'(SEED);
            rr_last     <= IW'(NUM_REQ - 1);
            winner      <= '0;
            reseed_pend <= 1'b0;
            seed_cap    <= '0;
            rnd_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A fresh reseed pulse supersedes any parked seed.
                    if (reseed) begin
                        lcg         <= seed_in;
                        reseed_pend <= 1'b0;
                    end else if (reseed_pend) begin
                        lcg         <= seed_cap;
                        reseed_pend <= 1'b0;
                    end else if (pick_vld) begin
                        winner <= pick;
                    end
                end
                GRANT: begin
                    lcg     <= lcg_step;
                    rnd_out <= lcg_step;
                    rr_last <= winner;
                end
                default: ;
            endcase
            if (state != IDLE && reseed) begin
                seed_cap    <= seed_in;
                reseed_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        ack = '0;
        if (state == GRANT)   gnt[winner] = 1'b1;
        if (state == DELIVER) ack[winner] = 1'b1;
    end

    assign rnd_valid = (state == DELIVER);
    assign busy      = (state != IDLE);
endmodule
